// File: rtl/pe_pkg.sv
// Shared definitions for the post-butterfly add/sub array: mode encoding,
// default moduli and mode decode helpers.
package pe_pkg;

  typedef enum logic [1:0] {
    MODE_K_NTT  = 2'd0,
    MODE_K_INTT = 2'd1,
    MODE_D_NTT  = 2'd2,
    MODE_D_INTT = 2'd3
  } pe_mode_e;

  localparam int Q_K_DEF = 3329;
  localparam int Q_D_DEF = 8380417;

  function automatic logic is_intt(input logic [1:0] mode);
    return mode[0];
  endfunction

  // Dilithium modes use the full lane word; Kyber modes split it in two.
  function automatic logic is_dil(input logic [1:0] mode);
    return mode[1];
  endfunction

endpackage

// File: rtl/pe_addsub_array_if.sv
// Beat-level stream bundle for pe_addsub_array: input operands with mode,
// output sum/difference with mode and range flag, valid/ready on each side.
interface pe_addsub_array_if #(
  parameter int LANES = 2,
  parameter int DW    = 24
);
  logic                  in_valid;
  logic                  in_ready;
  logic [1:0]            in_mode;
  logic [LANES*DW-1:0]   in_a;
  logic [LANES*DW-1:0]   in_b;
  logic                  out_valid;
  logic                  out_ready;
  logic [LANES*DW-1:0]   out_sum;
  logic [LANES*DW-1:0]   out_diff;
  logic [1:0]            out_mode;
  logic                  out_err;

  modport master (
    output in_valid, in_mode, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_sum, out_diff, out_mode, out_err
  );

  modport slave (
    input  in_valid, in_mode, in_a, in_b, out_ready,
    output in_ready, out_valid, out_sum, out_diff, out_mode, out_err
  );
endinterface

// File: rtl/pe_mod_lane.sv
// One lane of modular add/sub (S1) and conditional halve (S2); Kyber modes run
// two independent half-word coefficients. PE_ADDSUB_RANGE_CHECK_EN adds err_p0.
module pe_mod_lane
  import pe_pkg::*;
#(
  parameter int DW  = 24,
  parameter int Q_K = Q_K_DEF,
  parameter int Q_D = Q_D_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ld_p1,
  input  logic          ld_p2,
  input  logic [1:0]    mode_p0,
  input  logic [1:0]    mode_p1,
  input  logic [DW-1:0] a_p0,
  input  logic [DW-1:0] b_p0,
  output logic [DW-1:0] sum_p2,
  output logic [DW-1:0] diff_p2
`ifdef PE_ADDSUB_RANGE_CHECK_EN
  ,
  output logic          err_p0
`endif
);

  localparam int            H       = DW / 2;
  localparam logic [DW-1:0] QK      = DW'(Q_K);
  localparam logic [DW-1:0] QD      = DW'(Q_D);
  localparam logic [DW-1:0] LO_MASK = {{(DW-H){1'b0}}, {H{1'b1}}};

  logic [DW-1:0] sum_p1_d, sum_p1_q, diff_p1_d, diff_p1_q;
  logic [DW-1:0] sum_p2_d, sum_p2_q, diff_p2_d, diff_p2_q;

  function automatic logic [DW-1:0] mod_add(input logic [DW-1:0] a, b, q);
    logic [DW:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, q}) s = s - {1'b0, q};
    return DW'(s);
  endfunction

  function automatic logic [DW-1:0] mod_sub(input logic [DW-1:0] a, b, q);
    logic signed [DW+1:0] d;
    d = $signed({2'b00, a}) - $signed({2'b00, b});
    if (d[DW+1]) d = d + $signed({2'b00, q});
    return DW'(d);
  endfunction

  function automatic logic [DW-1:0] halve(input logic [DW-1:0] s, q);
    logic [DW:0] t;
    t = s[0] ? ({1'b0, s} + {1'b0, q}) : {1'b0, s};
    return DW'(t >> 1);
  endfunction

  function automatic logic [DW-1:0] lo_of(input logic [DW-1:0] w);
    return w & LO_MASK;
  endfunction

  function automatic logic [DW-1:0] hi_of(input logic [DW-1:0] w);
    return w >> H;
  endfunction

  function automatic logic [DW-1:0] pack(input logic [DW-1:0] lo, hi);
    return (hi << H) | (lo & LO_MASK);
  endfunction

  // S1: modular add/sub
  always_comb begin
    sum_p1_d  = sum_p1_q;
    diff_p1_d = diff_p1_q;
    if (ld_p1) begin
      if (is_dil(mode_p0)) begin
        sum_p1_d  = mod_add(a_p0, b_p0, QD);
        diff_p1_d = mod_sub(a_p0, b_p0, QD);
      end else begin
        sum_p1_d  = pack(mod_add(lo_of(a_p0), lo_of(b_p0), QK),
                         mod_add(hi_of(a_p0), hi_of(b_p0), QK));
        diff_p1_d = pack(mod_sub(lo_of(a_p0), lo_of(b_p0), QK),
                         mod_sub(hi_of(a_p0), hi_of(b_p0), QK));
      end
    end
  end

  // S2: halve the sum in INTT modes, difference passes through
  always_comb begin
    sum_p2_d  = sum_p2_q;
    diff_p2_d = diff_p2_q;
    if (ld_p2) begin
      diff_p2_d = diff_p1_q;
      if (!is_intt(mode_p1))   sum_p2_d = sum_p1_q;
      else if (is_dil(mode_p1)) sum_p2_d = halve(sum_p1_q, QD);
      else                      sum_p2_d = pack(halve(lo_of(sum_p1_q), QK),
                                                halve(hi_of(sum_p1_q), QK));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_p1_q  <= '0;
      diff_p1_q <= '0;
      sum_p2_q  <= '0;
      diff_p2_q <= '0;
    end else begin
      sum_p1_q  <= sum_p1_d;
      diff_p1_q <= diff_p1_d;
      sum_p2_q  <= sum_p2_d;
      diff_p2_q <= diff_p2_d;
    end
  end

  assign sum_p2  = sum_p2_q;
  assign diff_p2 = diff_p2_q;

`ifdef PE_ADDSUB_RANGE_CHECK_EN
  always_comb begin
    err_p0 = 1'b0;
    if (is_dil(mode_p0)) err_p0 = (a_p0 >= QD) || (b_p0 >= QD);
    else err_p0 = (lo_of(a_p0) >= QK) || (hi_of(a_p0) >= QK) ||
                  (lo_of(b_p0) >= QK) || (hi_of(b_p0) >= QK);
  end
`endif

endmodule

// File: rtl/pe_addsub_array.sv
// LANES-wide modular add/sub array with a two-stage valid/ready pipeline that
// carries each beat's mode. PE_ADDSUB_RANGE_CHECK_EN enables out_err.
module pe_addsub_array
  import pe_pkg::*;
#(
  parameter int LANES = 2,
  parameter int DW    = 24,
  parameter int Q_K   = Q_K_DEF,
  parameter int Q_D   = Q_D_DEF
) (
  input logic               clk,
  input logic               rst,
  pe_addsub_array_if.slave  bus
);

  logic                en, ld_p1, ld_p2;
  logic                vld_p1_d, vld_p1_q, vld_p2_d, vld_p2_q;
  logic [1:0]          mode_p1_d, mode_p1_q, mode_p2_d, mode_p2_q;
  logic [LANES*DW-1:0] sum_p2, diff_p2;

  // A full output stage that is not being drained freezes the whole pipe.
  always_comb begin
    en        = ~vld_p2_q | bus.out_ready;
    ld_p1     = en & bus.in_valid;
    ld_p2     = en & vld_p1_q;
    vld_p1_d  = en ? bus.in_valid : vld_p1_q;
    vld_p2_d  = en ? vld_p1_q : vld_p2_q;
    mode_p1_d = ld_p1 ? bus.in_mode : mode_p1_q;
    mode_p2_d = ld_p2 ? mode_p1_q : mode_p2_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1_q  <= 1'b0;
      vld_p2_q  <= 1'b0;
      mode_p1_q <= '0;
      mode_p2_q <= '0;
    end else begin
      vld_p1_q  <= vld_p1_d;
      vld_p2_q  <= vld_p2_d;
      mode_p1_q <= mode_p1_d;
      mode_p2_q <= mode_p2_d;
    end
  end

`ifdef PE_ADDSUB_RANGE_CHECK_EN
  logic [LANES-1:0] lane_err;
  logic             err_p1_d, err_p1_q, err_p2_d, err_p2_q;

  always_comb begin
    err_p1_d = ld_p1 ? |lane_err : err_p1_q;
    err_p2_d = ld_p2 ? err_p1_q : err_p2_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_p1_q <= 1'b0;
      err_p2_q <= 1'b0;
    end else begin
      err_p1_q <= err_p1_d;
      err_p2_q <= err_p2_d;
    end
  end

  assign bus.out_err = vld_p2_q & err_p2_q;
`else
  assign bus.out_err = 1'b0;
`endif

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    pe_mod_lane #(
      .DW  (DW),
      .Q_K (Q_K),
      .Q_D (Q_D)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .ld_p1   (ld_p1),
      .ld_p2   (ld_p2),
      .mode_p0 (bus.in_mode),
      .mode_p1 (mode_p1_q),
      .a_p0    (bus.in_a[i*DW +: DW]),
      .b_p0    (bus.in_b[i*DW +: DW]),
      .sum_p2  (sum_p2[i*DW +: DW]),
      .diff_p2 (diff_p2[i*DW +: DW])
`ifdef PE_ADDSUB_RANGE_CHECK_EN
      ,
      .err_p0  (lane_err[i])
`endif
    );
  end

  assign bus.in_ready  = en;
  assign bus.out_valid = vld_p2_q;
  assign bus.out_mode  = mode_p2_q;
  assign bus.out_sum   = sum_p2;
  assign bus.out_diff  = diff_p2;

endmodule

// File: tb/tb_pe_addsub_array.sv
// Randomised and directed bench for pe_addsub_array with a queue-based
// arithmetic reference model and stall-stability tracking.
module tb_pe_addsub_array;

  localparam int LANES = 2;
  localparam int DW    = 24;
  localparam int QK    = 3329;
  localparam int QD    = 8380417;
  localparam int W     = LANES * DW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pe_addsub_array_if #(.LANES(LANES), .DW(DW)) bus ();

  pe_addsub_array #(.LANES(LANES), .DW(DW), .Q_K(QK), .Q_D(QD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [W-1:0] sum;
    logic [W-1:0] diff;
    logic [1:0]   mode;
    logic         err;
    logic         dchk;
  } beat_t;

  beat_t        exp_q[$];
  int           checks = 0;
  int           errors = 0;
  int           n_out  = 0;
  bit           acc;
  bit           prev_stall;
  logic [W-1:0] prev_sum, prev_diff;
  logic [1:0]   prev_mode;
  logic         prev_err;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int madd(int a, int b, int q);
    return (a + b >= q) ? a + b - q : a + b;
  endfunction

  function automatic int msub(int a, int b, int q);
    return (a < b) ? a - b + q : a - b;
  endfunction

  function automatic int mhalf(int s, int q);
    return (s % 2 == 0) ? s / 2 : (s + q) / 2;
  endfunction

  function automatic beat_t model(input logic [1:0] m, input logic [W-1:0] a, input logic [W-1:0] b);
    beat_t r;
    bit    bad = 0;
    int    av, bv, s, q;
    r.sum = '0; r.diff = '0; r.mode = m;
    for (int i = 0; i < LANES; i++) begin
      if (m >= 2) begin
        q = QD; av = int'(a[i*DW +: DW]); bv = int'(b[i*DW +: DW]);
        if (av >= q || bv >= q) bad = 1;
        s = madd(av, bv, q);
        if (m == 3) s = mhalf(s, q);
        r.sum[i*DW +: DW]  = DW'(s);
        r.diff[i*DW +: DW] = DW'(msub(av, bv, q));
      end else begin
        for (int h = 0; h < 2; h++) begin
          q = QK; av = int'(a[i*DW+h*12 +: 12]); bv = int'(b[i*DW+h*12 +: 12]);
          if (av >= q || bv >= q) bad = 1;
          s = madd(av, bv, q);
          if (m == 1) s = mhalf(s, q);
          r.sum[i*DW+h*12 +: 12]  = 12'(s);
          r.diff[i*DW+h*12 +: 12] = 12'(msub(av, bv, q));
        end
      end
    end
    r.dchk = !bad;
`ifdef PE_ADDSUB_RANGE_CHECK_EN
    r.err = bad;
`else
    r.err = 1'b0;
`endif
    return r;
  endfunction

  function automatic int rand_coef(int q, int maxv, bit allow_bad);
    int r = int'($urandom_range(0, 9));
    if (allow_bad && r == 0) return int'($urandom_range(q, maxv));
    if (r == 1) return 0;
    if (r == 2) return q - 1;
    return int'($urandom_range(0, q - 1));
  endfunction

  function automatic logic [W-1:0] rand_word(input logic [1:0] m, input bit allow_bad);
    logic [W-1:0] w = '0;
    for (int i = 0; i < LANES; i++) begin
      if (m >= 2) w[i*DW +: DW] = DW'(rand_coef(QD, 16777215, allow_bad));
      else for (int h = 0; h < 2; h++) w[i*DW+h*12 +: 12] = 12'(rand_coef(QK, 4095, allow_bad));
    end
    return w;
  endfunction

  // One clock cycle: inputs are already driven at the falling edge.
  task automatic tick();
    beat_t e;
    #1;
    acc = bus.in_valid && bus.in_ready;
    if (acc) exp_q.push_back(model(bus.in_mode, bus.in_a, bus.in_b));
    if (prev_stall) begin
      check_val("hold_valid", bus.out_valid, 1);
      check_val("hold_sum", bus.out_sum, prev_sum);
      check_val("hold_diff", bus.out_diff, prev_diff);
      check_val("hold_mode", bus.out_mode, prev_mode);
      check_val("hold_err", bus.out_err, prev_err);
    end
    if (bus.out_valid && !bus.out_ready) check_val("stall_in_ready", bus.in_ready, 0);
    if (bus.out_valid && bus.out_ready) begin
      n_out++;
      if (exp_q.size() == 0) check_val("spurious_out", exp_q.size(), 1);
      else begin
        e = exp_q.pop_front();
        check_val("out_mode", bus.out_mode, e.mode);
        check_val("out_err", bus.out_err, e.err);
        if (e.dchk) begin
          check_val("out_sum", bus.out_sum, e.sum);
          check_val("out_diff", bus.out_diff, e.diff);
        end
      end
    end
    prev_stall = bus.out_valid && !bus.out_ready;
    prev_sum = bus.out_sum; prev_diff = bus.out_diff;
    prev_mode = bus.out_mode; prev_err = bus.out_err;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input logic [1:0] m, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.in_mode = m; bus.in_a = a; bus.in_b = b; bus.in_valid = 1'b1;
    acc = 0;
    for (int k = 0; k < 20 && !acc; k++) tick();
    check_val("send_accepted", acc, 1);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 1;
    for (int k = 0; k < 8; k++) begin
      #1;
      if (bus.out_valid) return;
      tick();
      lat++;
    end
  endtask

  // alt: modes 0,3,1,2 in turn; rnd: random valid/ready and out-of-range injection.
  task automatic run_stream(input int nbeats, input bit alt, input bit rnd,
                            input int stall_lo, input int stall_hi, input int max_cyc);
    int           sent = 0;
    logic [1:0]   m;
    logic [1:0]   alt_seq [4] = '{2'd0, 2'd3, 2'd1, 2'd2};
    for (int c = 0; c < max_cyc; c++) begin
      bus.out_ready = rnd ? ($urandom_range(0, 9) < 7) : !(c >= stall_lo && c <= stall_hi);
      if (sent < nbeats && !bus.in_valid && (!rnd || $urandom_range(0, 3) != 0)) begin
        m = alt ? alt_seq[sent % 4] : 2'($urandom_range(0, 3));
        bus.in_mode = m;
        bus.in_a = rand_word(m, rnd);
        bus.in_b = rand_word(m, rnd);
        bus.in_valid = 1'b1;
      end
      tick();
      if (acc) begin sent++; bus.in_valid = 1'b0; end
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    check_val("stream_all_sent", sent, nbeats);
  endtask

  initial begin
    int           lat, n0;
    logic [W-1:0] a, b;
    rst = 1'b0;
    bus.in_valid = 1'b0; bus.in_mode = 2'd0; bus.in_a = '0; bus.in_b = '0;
    bus.out_ready = 1'b1;
    prev_stall = 0;
    #2 rst = 1'b1;
    @(negedge clk); @(negedge clk);
    check_val("rst_out_valid", bus.out_valid, 0);
    check_val("rst_out_sum", bus.out_sum, 0);
    check_val("rst_out_diff", bus.out_diff, 0);
    check_val("rst_out_mode", bus.out_mode, 0);
    check_val("rst_out_err", bus.out_err, 0);
    rst = 1'b0;
    #1 check_val("rst_in_ready", bus.in_ready, 1);
    @(negedge clk);

    a = '0; b = '0;
    a[23:0] = {12'd3000, 12'd5}; b[23:0] = {12'd1000, 12'd10};
    send(2'd0, a, b);
    wait_out(lat);
    check_val("k_ntt_latency", lat, 2);
    check_val("k_ntt_sum", bus.out_sum[23:0], {12'd671, 12'd15});
    check_val("k_ntt_diff", bus.out_diff[23:0], {12'd2000, 12'd3324});
    tick();
    send(2'd1, a, b);
    wait_out(lat);
    check_val("k_intt_sum", bus.out_sum[23:0], {12'd2000, 12'd1672});
    check_val("k_intt_diff", bus.out_diff[23:0], {12'd2000, 12'd3324});
    tick();

    a = '0; b = '0; a[23:0] = 24'd8380416; b[23:0] = 24'd1;
    send(2'd2, a, b);
    wait_out(lat);
    check_val("d_ntt_sum", bus.out_sum[23:0], 24'd0);
    check_val("d_ntt_diff", bus.out_diff[23:0], 24'd8380415);
    tick();
    a[23:0] = 24'd2;
    send(2'd3, a, b);
    wait_out(lat);
    check_val("d_intt_sum", bus.out_sum[23:0], 24'd4190210);
    check_val("d_intt_diff", bus.out_diff[23:0], 24'd1);
    tick();

    run_stream(8, 1'b1, 1'b0, -1, -1, 14);

    n0 = n_out;
    run_stream(6, 1'b0, 1'b0, 3, 5, 16);
    check_val("bp_beat_count", n_out - n0, 6);

    bus.in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus.in_mode = 2'($urandom_range(0, 3));
      bus.in_a = rand_word(bus.in_mode, 0);
      bus.in_b = rand_word(bus.in_mode, 0);
      tick();
    end
    bus.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check_val("midrst_out_valid", bus.out_valid, 0);
    check_val("midrst_out_sum", bus.out_sum, 0);
    exp_q.delete();
    prev_stall = 0;
    @(negedge clk);
    rst = 1'b0;
    send(2'd3, rand_word(2'd3, 0), rand_word(2'd3, 0));
    wait_out(lat);
    check_val("post_rst_latency", lat, 2);
    tick();

    a = '0; b = '0; a[47:24] = 24'd5; b[47:24] = 24'd8380417;
    send(2'd2, a, b);
    wait_out(lat);
`ifdef PE_ADDSUB_RANGE_CHECK_EN
    check_val("range_err_set", bus.out_err, 1);
`else
    check_val("range_err_set", bus.out_err, 0);
`endif
    tick();
    b[47:24] = 24'd7;
    send(2'd2, a, b);
    wait_out(lat);
    check_val("range_err_clear", bus.out_err, 0);
    tick();

    run_stream(300, 1'b0, 1'b1, -1, -1, 900);
    for (int k = 0; k < 6; k++) tick();
    check_val("drain_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
